// File: rtl/monitor_porta.sv
// monitor_porta: reads the door controller's display outputs (7-seg HEX plus green/red LEDs).
// It filters the pattern, decodes it back into the door state and flags illegal state sequences.
// It also counts completed open/close cycles and error events.
// Optional build macro MONITOR_TIMEOUT_EN adds a dwell timer that flags a door stuck in motion;
// without it err_timeout is tied low and no timer logic exists.
module monitor_porta #(
  parameter int STABLE_CYCLES = 2,
  parameter int MAX_MOV       = 200,
  parameter int CNT_W         = 8
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic [6:0]       i_hex,
  input  logic             i_led_verde,
  input  logic             i_led_vermelho,
  input  logic             i_clear_err,
  output logic [2:0]       o_estado,
  output logic             o_estado_valido,
  output logic             o_mudou,
  output logic             o_err_transicao,
  output logic             o_err_codigo,
  output logic             o_err_timeout,
  output logic [CNT_W-1:0] o_num_ciclos,
  output logic [CNT_W-1:0] o_num_erros
);

  typedef enum logic [2:0] {
    ST_DESCONHECIDO = 3'd0,
    ST_FECHADO      = 3'd1,
    ST_ABRINDO      = 3'd2,
    ST_ABERTO       = 3'd3,
    ST_FECHANDO     = 3'd4
  } estado_t;

  // Active-low segment codes {g,f,e,d,c,b,a}
  localparam logic [6:0] HEX_F = 7'b0001110;
  localparam logic [6:0] HEX_O = 7'b1000000;
  localparam logic [6:0] HEX_A = 7'b0001000;

  // Stability counter must reach STABLE_CYCLES+1, where it parks after an acceptance
  localparam int SCNT_W = $clog2(STABLE_CYCLES + 2);

  if (STABLE_CYCLES < 1 || MAX_MOV < 2 || CNT_W < 2) begin : g_param_check
    $error("monitor_porta: STABLE_CYCLES>=1, MAX_MOV>=2 and CNT_W>=2 are required");
  end

  // Saturating add of a small event count to a CNT_W counter
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
    if (s[CNT_W]) return {CNT_W{1'b1}};
    return s[CNT_W-1:0];
  endfunction

  // Legal door-state successors (re-open from FECHANDO included)
  function automatic logic is_legal(input estado_t from, input estado_t to);
    logic ok;
    ok = 1'b0;
    case (from)
      ST_FECHADO:  ok = (to == ST_ABRINDO);
      ST_ABRINDO:  ok = (to == ST_ABERTO);
      ST_ABERTO:   ok = (to == ST_FECHANDO);
      ST_FECHANDO: ok = (to == ST_FECHADO) || (to == ST_ABRINDO);
      default:     ok = 1'b0;
    endcase
    return ok;
  endfunction

  logic [8:0]        w_tuple;
  logic [8:0]        r_smp;
  logic [SCNT_W-1:0] r_cnt, w_cnt_nxt;
  logic              w_accept;
  estado_t           w_dec;
  logic              w_dec_ok;

  estado_t           r_estado, w_estado_nxt;
  logic              r_valido, w_valido_nxt;
  logic              r_mudou, w_mudou_nxt;
  logic              r_inv, w_inv_nxt;
  logic              r_err_tr, w_err_tr_nxt;
  logic              r_err_cod, w_err_cod_nxt;
  logic [CNT_W-1:0]  r_ciclos, w_ciclos_nxt;
  logic [CNT_W-1:0]  r_erros, w_erros_nxt;
  logic              w_tr_new, w_cod_new, w_to_new;
  logic [1:0]        w_err_inc;

  assign w_tuple  = {i_hex, i_led_verde, i_led_vermelho};
  // A sample that has been held STABLE_CYCLES edges is accepted exactly once
  assign w_accept = (r_cnt == SCNT_W'(STABLE_CYCLES));

  // Stability counter: restarts at 1 on a new sample, parks one past the acceptance point
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_tuple != r_smp) begin
      w_cnt_nxt = SCNT_W'(1);
    end else if (r_cnt != SCNT_W'(STABLE_CYCLES + 1)) begin
      w_cnt_nxt = r_cnt + SCNT_W'(1);
    end
  end

  // Decode the registered display tuple into a door state
  always_comb begin
    w_dec    = ST_DESCONHECIDO;
    w_dec_ok = 1'b0;
    case (r_smp)
      {HEX_F, 2'b01}: begin w_dec = ST_FECHADO;  w_dec_ok = 1'b1; end
      {HEX_A, 2'b11}: begin w_dec = ST_ABRINDO;  w_dec_ok = 1'b1; end
      {HEX_O, 2'b10}: begin w_dec = ST_ABERTO;   w_dec_ok = 1'b1; end
      {HEX_F, 2'b11}: begin w_dec = ST_FECHANDO; w_dec_ok = 1'b1; end
      default:        begin w_dec = ST_DESCONHECIDO; w_dec_ok = 1'b0; end
    endcase
  end

  // Acceptance: state update, transition check, cycle counting, code-error detection
  always_comb begin
    w_estado_nxt = r_estado;
    w_valido_nxt = r_valido;
    w_mudou_nxt  = 1'b0;
    w_inv_nxt    = r_inv;
    w_ciclos_nxt = r_ciclos;
    w_tr_new     = 1'b0;
    w_cod_new    = 1'b0;
    if (w_accept) begin
      if (!w_dec_ok) begin
        // Undecodable pattern: state is held and only the first acceptance of the episode counts
        w_valido_nxt = 1'b0;
        if (!r_inv) begin
          w_cod_new = 1'b1;
          w_inv_nxt = 1'b1;
        end
      end else begin
        w_valido_nxt = 1'b1;
        w_inv_nxt    = 1'b0;
        if (w_dec != r_estado) begin
          w_estado_nxt = w_dec;
          w_mudou_nxt  = 1'b1;
          if (r_estado != ST_DESCONHECIDO && !is_legal(r_estado, w_dec)) begin
            w_tr_new = 1'b1;
          end
          if (r_estado == ST_FECHANDO && w_dec == ST_FECHADO) begin
            w_ciclos_nxt = sat_add(r_ciclos, 2'd1);
          end
        end
      end
    end
  end

`ifdef MONITOR_TIMEOUT_EN
  localparam int DW_W = $clog2(MAX_MOV + 1);

  logic [DW_W-1:0] r_dwell, w_dwell_nxt;
  logic            r_err_to, w_err_to_nxt;

  // Dwell timer: restarts on any state change, fires once when a motion state reaches MAX_MOV
  always_comb begin
    w_dwell_nxt = r_dwell;
    w_to_new    = 1'b0;
    if (w_mudou_nxt) begin
      w_dwell_nxt = '0;
    end else if ((r_estado == ST_ABRINDO || r_estado == ST_FECHANDO) &&
                 r_dwell != DW_W'(MAX_MOV)) begin
      w_dwell_nxt = r_dwell + DW_W'(1);
      if (r_dwell == DW_W'(MAX_MOV - 1)) w_to_new = 1'b1;
    end
  end

  assign w_err_to_nxt  = (i_clear_err ? 1'b0 : r_err_to) | w_to_new;
  assign o_err_timeout = r_err_to;

  // Dwell timer and timeout flag registers
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_dwell  <= '0;
      r_err_to <= 1'b0;
    end else begin
      r_dwell  <= w_dwell_nxt;
      r_err_to <= w_err_to_nxt;
    end
  end
`else
  assign w_to_new      = 1'b0;
  assign o_err_timeout = 1'b0;
`endif

  // A new error in the same cycle as clear_err survives the clear
  assign w_err_inc     = 2'(w_tr_new) + 2'(w_cod_new) + 2'(w_to_new);
  assign w_err_tr_nxt  = (i_clear_err ? 1'b0 : r_err_tr) | w_tr_new;
  assign w_err_cod_nxt = (i_clear_err ? 1'b0 : r_err_cod) | w_cod_new;
  assign w_erros_nxt   = sat_add(i_clear_err ? '0 : r_erros, w_err_inc);

  // Filter and monitor state registers
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_smp     <= '0;
      r_cnt     <= '0;
      r_estado  <= ST_DESCONHECIDO;
      r_valido  <= 1'b0;
      r_mudou   <= 1'b0;
      r_inv     <= 1'b0;
      r_err_tr  <= 1'b0;
      r_err_cod <= 1'b0;
      r_ciclos  <= '0;
      r_erros   <= '0;
    end else begin
      r_smp     <= w_tuple;
      r_cnt     <= w_cnt_nxt;
      r_estado  <= w_estado_nxt;
      r_valido  <= w_valido_nxt;
      r_mudou   <= w_mudou_nxt;
      r_inv     <= w_inv_nxt;
      r_err_tr  <= w_err_tr_nxt;
      r_err_cod <= w_err_cod_nxt;
      r_ciclos  <= w_ciclos_nxt;
      r_erros   <= w_erros_nxt;
    end
  end

  assign o_estado        = r_estado;
  assign o_estado_valido = r_valido;
  assign o_mudou         = r_mudou;
  assign o_err_transicao = r_err_tr;
  assign o_err_codigo    = r_err_cod;
  assign o_num_ciclos    = r_ciclos;
  assign o_num_erros     = r_erros;

endmodule

// File: tb/tb_monitor_porta.sv
// Testbench for monitor_porta: directed scenarios plus randomized display traffic,
// compared every cycle against a history-based reference model.
module tb_monitor_porta;

  localparam int STABLE = 2;
  localparam int MAXMV  = 10;
  localparam int CW     = 4;
  localparam int SATMAX = (1 << CW) - 1;
`ifdef MONITOR_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam logic [8:0] T_FECHADO  = {7'b0001110, 2'b01};
  localparam logic [8:0] T_ABRINDO  = {7'b0001000, 2'b11};
  localparam logic [8:0] T_ABERTO   = {7'b1000000, 2'b10};
  localparam logic [8:0] T_FECHANDO = {7'b0001110, 2'b11};
  localparam logic [8:0] T_BLANK    = {7'h7F, 2'b10};

  logic          clk = 1'b0;
  logic          rst_n;
  logic [8:0]    tup;
  logic          clr;
  logic [2:0]    o_estado;
  logic          o_estado_valido, o_mudou, o_err_transicao, o_err_codigo, o_err_timeout;
  logic [CW-1:0] o_num_ciclos, o_num_erros;

  always #5 clk = ~clk;

  monitor_porta #(.STABLE_CYCLES(STABLE), .MAX_MOV(MAXMV), .CNT_W(CW)) dut (
    .i_clock        (clk),
    .i_reset_n      (rst_n),
    .i_hex          (tup[8:2]),
    .i_led_verde    (tup[1]),
    .i_led_vermelho (tup[0]),
    .i_clear_err    (clr),
    .o_estado       (o_estado),
    .o_estado_valido(o_estado_valido),
    .o_mudou        (o_mudou),
    .o_err_transicao(o_err_transicao),
    .o_err_codigo   (o_err_codigo),
    .o_err_timeout  (o_err_timeout),
    .o_num_ciclos   (o_num_ciclos),
    .o_num_erros    (o_num_erros)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int mud_cnt  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @%0t got=%0d exp=%0d", tag, $time, got, exp);
  endtask

  // Reference model: keeps the recent sample history and applies the acceptance rules directly
  logic [8:0] hist[$];
  int m_estado, m_ciclos, m_erros, m_since;
  bit m_valido, m_mudou, m_etr, m_ecod, m_eto, m_inv, m_to_done;

  function automatic int decode(input logic [8:0] t);
    if (t == T_FECHADO)  return 1;
    if (t == T_ABRINDO)  return 2;
    if (t == T_ABERTO)   return 3;
    if (t == T_FECHANDO) return 4;
    return -1;
  endfunction

  function automatic bit legal(input int a, input int b);
    return (a == 1 && b == 2) || (a == 2 && b == 3) || (a == 3 && b == 4) ||
           (a == 4 && b == 1) || (a == 4 && b == 2);
  endfunction

  function automatic int run_len();
    int n = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] == hist[hist.size() - 1]) n++;
      else break;
    end
    return n;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_estado = 0; m_ciclos = 0; m_erros = 0; m_since = 0;
    m_valido = 0; m_mudou = 0; m_etr = 0; m_ecod = 0; m_eto = 0; m_inv = 0; m_to_done = 0;
  endtask

  task automatic model_edge(input logic [8:0] t, input bit rstn, input bit c);
    int  nerr = 0;
    int  d;
    bit  changed = 0, n_tr = 0, n_cod = 0, n_to = 0;
    if (!rstn) begin
      model_reset();
      return;
    end
    m_mudou = 0;
    if (hist.size() > 0 && run_len() == STABLE) begin
      d = decode(hist[hist.size() - 1]);
      if (d < 0) begin
        m_valido = 0;
        if (!m_inv) begin m_inv = 1; n_cod = 1; nerr++; end
      end else begin
        m_valido = 1;
        m_inv    = 0;
        if (d != m_estado) begin
          if (m_estado != 0 && !legal(m_estado, d)) begin n_tr = 1; nerr++; end
          if (m_estado == 4 && d == 1 && m_ciclos < SATMAX) m_ciclos++;
          m_estado = d;
          m_mudou  = 1;
          changed  = 1;
        end
      end
    end
    if (changed) begin
      m_since = 0; m_to_done = 0;
    end else begin
      m_since++;
      if (TO_EN && (m_estado == 2 || m_estado == 4) && m_since >= MAXMV && !m_to_done) begin
        m_to_done = 1; n_to = 1; nerr++;
      end
    end
    if (c) begin m_etr = 0; m_ecod = 0; m_eto = 0; m_erros = 0; end
    if (n_tr)  m_etr  = 1;
    if (n_cod) m_ecod = 1;
    if (n_to)  m_eto  = 1;
    m_erros = (m_erros + nerr > SATMAX) ? SATMAX : m_erros + nerr;
    hist.push_back(t);
    if (hist.size() > STABLE + 2) void'(hist.pop_front());
  endtask

  task automatic compare_all();
    check_eq("estado",  32'(o_estado),        32'(m_estado));
    check_eq("valido",  32'(o_estado_valido), 32'(m_valido));
    check_eq("mudou",   32'(o_mudou),         32'(m_mudou));
    check_eq("err_tr",  32'(o_err_transicao), 32'(m_etr));
    check_eq("err_cod", 32'(o_err_codigo),    32'(m_ecod));
    check_eq("err_to",  32'(o_err_timeout),   32'(m_eto));
    check_eq("ciclos",  32'(o_num_ciclos),    32'(m_ciclos));
    check_eq("erros",   32'(o_num_erros),     32'(m_erros));
  endtask

  task automatic cycle(input logic [8:0] t, input bit c);
    tup = t;
    clr = c;
    @(posedge clk);
    model_edge(t, rst_n, c);
    #1;
    if (o_mudou) mud_cnt++;
    compare_all();
  endtask

  task automatic hold(input logic [8:0] t, input int n);
    for (int i = 0; i < n; i++) cycle(t, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle(T_ABERTO, 1'b1);
    cycle(T_ABERTO, 1'b0);
    rst_n = 1'b1;
  endtask

  logic [8:0] valids[4] = '{T_FECHADO, T_ABRINDO, T_ABERTO, T_FECHANDO};

  initial begin
    rst_n = 1'b0; tup = '0; clr = 1'b0;
    model_reset();
    do_reset();
    check_eq("rst_estado", 32'(o_estado), 32'd0);
    check_eq("rst_erros",  32'(o_num_erros), 32'd0);

    // First acceptance after reset
    mud_cnt = 0;
    cycle(T_FECHADO, 1'b0);
    cycle(T_FECHADO, 1'b0);
    check_eq("lat_before", 32'(o_estado), 32'd0);
    cycle(T_FECHADO, 1'b0);
    check_eq("lat_edge3", 32'(o_estado), 32'd1);
    hold(T_FECHADO, 2);
    check_eq("first_mudou", 32'(mud_cnt), 32'd1);
    check_eq("first_valido", 32'(o_estado_valido), 32'd1);

    // Full legal cycle
    mud_cnt = 0;
    hold(T_ABRINDO, 4); hold(T_ABERTO, 4); hold(T_FECHANDO, 4); hold(T_FECHADO, 4);
    check_eq("cyc_mudou", 32'(mud_cnt), 32'd4);
    check_eq("cyc_ciclos", 32'(o_num_ciclos), 32'd1);
    check_eq("cyc_erros", 32'(o_num_erros), 32'd0);

    // Short glitch is filtered
    mud_cnt = 0;
    hold(T_ABERTO, 1); hold(T_FECHADO, 4);
    check_eq("glitch_estado", 32'(o_estado), 32'd1);
    check_eq("glitch_mudou", 32'(mud_cnt), 32'd0);
    check_eq("glitch_erros", 32'(o_num_erros), 32'd0);

    // Illegal transition, then clear
    hold(T_ABERTO, 4);
    check_eq("ill_estado", 32'(o_estado), 32'd3);
    check_eq("ill_flag", 32'(o_err_transicao), 32'd1);
    check_eq("ill_erros", 32'(o_num_erros), 32'd1);
    cycle(T_ABERTO, 1'b1);
    check_eq("clr_flag", 32'(o_err_transicao), 32'd0);
    check_eq("clr_erros", 32'(o_num_erros), 32'd0);
    check_eq("clr_ciclos", 32'(o_num_ciclos), 32'd1);

    // Undecodable pattern, counted once per episode
    hold(T_BLANK, 4);
    check_eq("code_flag", 32'(o_err_codigo), 32'd1);
    check_eq("code_valido", 32'(o_estado_valido), 32'd0);
    check_eq("code_estado", 32'(o_estado), 32'd3);
    hold(T_BLANK, 4);
    check_eq("code_once", 32'(o_num_erros), 32'd1);
    hold(T_FECHANDO, 4);
    check_eq("code_recover", 32'(o_estado), 32'd4);

    // Long dwell in ABRINDO
    do_reset();
    hold(T_FECHADO, 4);
    hold(T_ABRINDO, 30);
    check_eq("to_flag", 32'(o_err_timeout), TO_EN ? 32'd1 : 32'd0);
    check_eq("to_erros", 32'(o_num_erros), TO_EN ? 32'd1 : 32'd0);

    // Error wins over a simultaneous clear
    cycle(T_FECHADO, 1'b0);
    cycle(T_FECHADO, 1'b0);
    cycle(T_FECHADO, 1'b1);
    check_eq("clrwin_flag", 32'(o_err_transicao), 32'd1);
    check_eq("clrwin_erros", 32'(o_num_erros), 32'd1);
    check_eq("clrwin_to", 32'(o_err_timeout), 32'd0);

    // Counter saturation
    do_reset();
    hold(T_FECHADO, 3);
    for (int i = 0; i < 17; i++) begin
      hold(T_ABRINDO, 3); hold(T_ABERTO, 3); hold(T_FECHANDO, 3); hold(T_FECHADO, 3);
    end
    check_eq("sat_ciclos", 32'(o_num_ciclos), 32'(SATMAX));
    for (int i = 0; i < 10; i++) begin
      hold(T_ABERTO, 3); hold(T_FECHADO, 3);
    end
    check_eq("sat_erros", 32'(o_num_erros), 32'(SATMAX));

    // Randomized traffic with occasional resets and clears
    for (int s = 0; s < 800; s++) begin
      logic [8:0] t;
      int         n;
      if ($urandom_range(0, 49) == 0) do_reset();
      if ($urandom_range(0, 9) < 7) t = valids[$urandom_range(0, 3)];
      else t = 9'($urandom);
      n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(8, 14)) : int'($urandom_range(1, 4));
      for (int k = 0; k < n; k++) cycle(t, $urandom_range(0, 19) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
